debounce_bank: RTL

Multi-channel, parametrised switch and button debouncer for the stopwatch front panel. It replaces per-input single debouncers with one bank. Each of N asynchronous inputs is synchronised and filtered against a shared millisecond-scale tick. Each channel produces a stable level plus single-cycle rise and fall strobes, which feed the control FSM directly.

---
 rtl/debounce_pkg.sv | 18 +
 rtl/debounce_tick.sv | 33 +++
 rtl/debounce_bank.sv | 116 +++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and front-panel channel map for the stopwatch input debouncer.
package debounce_pkg;

    localparam int DEFAULT_CLK_FREQ_KHZ = 100_000;
    localparam int DEFAULT_STABLE_TICKS = 4;
    localparam int DEFAULT_LONG_TICKS   = 1000;

    // Bit positions of the front-panel buttons within src/dst
    typedef enum logic [1:0] {
        PANEL_START_STOP = 2'd0,
        PANEL_LAP        = 2'd1,
        PANEL_RESET      = 2'd2,
        PANEL_MODE       = 2'd3
    } panel_ch_e;

    localparam int PANEL_CHANNELS = 4;

endpackage

// File: rtl/debounce_tick.sv
// Free-running divider producing the one-cycle sampling tick shared by every
// debounce channel.
module debounce_tick #(
    parameter int TICK_DIV = 100_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    generate
        if (TICK_DIV <= 1) begin : g_every_cycle
            assign tick = 1'b1;
        end else begin : g_divider
            localparam int TW = $clog2(TICK_DIV);

            logic [TW-1:0] tcnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tcnt <= '0;
                end else if (tcnt == TW'(TICK_DIV - 1)) begin
                    tcnt <= '0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end

            assign tick = (tcnt == TW'(TICK_DIV - 1));
        end
    endgenerate

endmodule

// File: rtl/debounce_bank.sv
// N-channel switch debouncer: 2-flop synchroniser, tick-based stability filter,
// registered level plus rise/fall strobes. Define DEBOUNCE_BANK_LONG_PRESS_EN for long_press.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int N            = 4,
    parameter int CLK_FREQ_KHZ = DEFAULT_CLK_FREQ_KHZ,
    parameter int TICK_DIV     = CLK_FREQ_KHZ,
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS,
    parameter int LONG_TICKS   = DEFAULT_LONG_TICKS,
    parameter bit RESET_LEVEL  = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] src,
    output logic [N-1:0] dst,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic [N-1:0] long_press
);

    localparam int CW = $clog2(STABLE_TICKS + 1);

    logic tick;

    generate
        if (TICK_DIV < 1 || STABLE_TICKS < 1 || LONG_TICKS < 1) begin : g_bad_params
            $error("debounce_bank: TICK_DIV, STABLE_TICKS and LONG_TICKS must all be >= 1");
        end
    endgenerate

    debounce_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    generate
        for (genvar i = 0; i < N; i++) begin : g_chan
            logic          s0;
            logic          s1;
            logic          dst_q;
            logic          rise_q;
            logic          fall_q;
            logic [CW-1:0] cnt;
            logic          commit;

            assign commit = (s1 != dst_q) && tick && (cnt == CW'(STABLE_TICKS - 1));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s0 <= RESET_LEVEL;
                    s1 <= RESET_LEVEL;
                end else begin
                    s0 <= src[i];
                    s1 <= s0;
                end
            end

            // Any return to the committed level throws away accumulated ticks
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt    <= '0;
                    dst_q  <= RESET_LEVEL;
                    rise_q <= 1'b0;
                    fall_q <= 1'b0;
                end else begin
                    rise_q <= commit & s1;
                    fall_q <= commit & ~s1;
                    if (s1 == dst_q) begin
                        cnt <= '0;
                    end else if (commit) begin
                        dst_q <= s1;
                        cnt   <= '0;
                    end else if (tick) begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end

            assign dst[i]  = dst_q;
            assign rise[i] = rise_q;
            assign fall[i] = fall_q;

`ifdef DEBOUNCE_BANK_LONG_PRESS_EN
            localparam int LW = $clog2(LONG_TICKS + 1);

            logic [LW-1:0] lcnt;
            logic          lp_q;

            // Saturates at LONG_TICKS so a held button fires only once
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lcnt <= '0;
                    lp_q <= 1'b0;
                end else begin
                    lp_q <= 1'b0;
                    if (!dst_q) begin
                        lcnt <= '0;
                    end else if (tick && (lcnt != LW'(LONG_TICKS))) begin
                        lcnt <= lcnt + 1'b1;
                        lp_q <= (lcnt == LW'(LONG_TICKS - 1));
                    end
                end
            end

            assign long_press[i] = lp_q;
`else
            assign long_press[i] = 1'b0;
`endif
        end
    endgenerate

endmodule
